// File: rtl/cpu7_icu_pkg.sv
// Shared definitions for the cpu7 instruction cache unit: FSM encoding,
// block-offset width and the helper that extracts the 64-bit block tag.
package cpu7_icu_pkg;

    localparam logic [1:0] ICU_IDLE  = 2'd0;
    localparam logic [1:0] ICU_BREQ  = 2'd1;
    localparam logic [1:0] ICU_BWAIT = 2'd2;

    localparam int ICU_OFS_W  = 3;
    localparam int ICU_TAG_HI = 31;
    localparam int ICU_TAG_LO = ICU_OFS_W;
    localparam int ICU_TAG_W  = ICU_TAG_HI - ICU_TAG_LO + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = ICU_IDLE,
        ST_BREQ  = ICU_BREQ,
        ST_BWAIT = ICU_BWAIT
    } icu_state_e;

    function automatic logic [ICU_TAG_W-1:0] icu_tag_of(input logic [31:0] addr);
        return addr[ICU_TAG_HI:ICU_TAG_LO];
    endfunction

endpackage

// File: rtl/cpu7_icu_linebuf.sv
// One-entry line buffer: block tag compare plus storage of the last
// error-free fetched block. Only instantiated when ICU_LINEBUF_EN is defined.
module cpu7_icu_linebuf
    import cpu7_icu_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ICU_TAG_W-1:0] lookup_tag,
    input  logic                 fill_en,
    input  logic [ICU_TAG_W-1:0] fill_tag,
    input  logic [DW-1:0]        fill_data,
    input  logic                 inv,
    output logic                 hit,
    output logic [DW-1:0]        data
);

    logic                 valid_r;
    logic [ICU_TAG_W-1:0] tag_r;
    logic [DW-1:0]        data_r;

    // Entry update; invalidate wins so a fill racing a barrier is not installed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            tag_r   <= {ICU_TAG_W{1'b0}};
            data_r  <= {DW{1'b0}};
        end else if (inv) begin
            valid_r <= 1'b0;
        end else if (fill_en) begin
            valid_r <= 1'b1;
            tag_r   <= fill_tag;
            data_r  <= fill_data;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign hit  = valid_r & (tag_r == lookup_tag);
    assign data = data_r;

endmodule

// File: rtl/cpu7_icu.sv
// cpu7_icu: responder for IFU fetches, reading aligned 64-bit blocks from the BIU.
// Define ICU_LINEBUF_EN to add a one-entry line buffer in front of the bus.
module cpu7_icu
    import cpu7_icu_pkg::*;
#(
    parameter int BUS_AW = 32,
    parameter int BUS_DW = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ifu_icu_req_ic1,
    input  logic [31:0]       ifu_icu_addr_ic1,
    output logic              icu_ifu_ack_ic1,
    input  logic              ifu_icu_cancel,
    output logic [BUS_DW-1:0] icu_ifu_data_ic2,
    output logic              icu_ifu_data_valid_ic2,
    output logic              icu_ifu_ex_ic2,
    output logic              icu_biu_req,
    output logic [BUS_AW-1:0] icu_biu_addr,
    input  logic              biu_icu_ack,
    input  logic [BUS_DW-1:0] biu_icu_data,
    input  logic              biu_icu_data_valid,
    input  logic              biu_icu_err,
    input  logic              exu_icu_ibar
);

    icu_state_e           state_r, state_nxt_s;
    logic                 drop_r, drop_nxt_s;
    logic [ICU_TAG_W-1:0] tag_r, tag_nxt_s;
    logic                 biu_req_r, biu_req_nxt_s;
    logic [BUS_DW-1:0]    data_r, data_nxt_s;
    logic                 ex_r, ex_nxt_s;
    logic                 dv_r, dv_nxt_s;
    logic                 hit_pend_r, hit_pend_nxt_s;
    logic                 ack_s, hit_s, fill_s;
    logic [BUS_DW-1:0]    lb_data_s;
    logic [ICU_TAG_W-1:0] req_tag_s;

    assign req_tag_s = icu_tag_of(ifu_icu_addr_ic1);
    assign ack_s     = ifu_icu_req_ic1 & (state_r == ST_IDLE) & ~drop_r;
    assign fill_s    = (state_r == ST_BWAIT) & biu_icu_data_valid & ~drop_r
                       & ~ifu_icu_cancel & ~biu_icu_err;

`ifdef ICU_LINEBUF_EN
    cpu7_icu_linebuf #(
        .DW (BUS_DW)
    ) u_linebuf (
        .clk        (clk),
        .rst_n      (resetn),
        .lookup_tag (req_tag_s),
        .fill_en    (fill_s),
        .fill_tag   (tag_r),
        .fill_data  (biu_icu_data),
        .inv        (exu_icu_ibar),
        .hit        (hit_s),
        .data       (lb_data_s)
    );
    logic unused_s;
    assign unused_s = &{1'b0, ifu_icu_addr_ic1[2:0]};
`else
    assign hit_s     = 1'b0;
    assign lb_data_s = {BUS_DW{1'b0}};
    logic unused_s;
    assign unused_s = &{1'b0, ifu_icu_addr_ic1[2:0], exu_icu_ibar, fill_s};
`endif

    // Next-state and registered-output logic of the fetch FSM
    always_comb begin
        state_nxt_s    = state_r;
        drop_nxt_s     = drop_r;
        tag_nxt_s      = tag_r;
        biu_req_nxt_s  = biu_req_r;
        data_nxt_s     = data_r;
        ex_nxt_s       = ex_r;
        dv_nxt_s       = 1'b0;
        hit_pend_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ack_s && hit_s) begin
                    // Buffer hit: answer next cycle, a cancel now kills it
                    if (!ifu_icu_cancel) begin
                        dv_nxt_s       = 1'b1;
                        hit_pend_nxt_s = 1'b1;
                        data_nxt_s     = lb_data_s;
                        ex_nxt_s       = 1'b0;
                    end else begin
                        dv_nxt_s = 1'b0;
                    end
                end else if (ack_s) begin
                    state_nxt_s   = ST_BREQ;
                    tag_nxt_s     = req_tag_s;
                    biu_req_nxt_s = 1'b1;
                    drop_nxt_s    = ifu_icu_cancel;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BREQ: begin
                if (ifu_icu_cancel) begin
                    drop_nxt_s = 1'b1;
                end else begin
                    drop_nxt_s = drop_r;
                end
                if (biu_icu_ack) begin
                    state_nxt_s   = ST_BWAIT;
                    biu_req_nxt_s = 1'b0;
                end else begin
                    biu_req_nxt_s = 1'b1;
                end
            end
            ST_BWAIT: begin
                if (biu_icu_data_valid) begin
                    state_nxt_s = ST_IDLE;
                    if (!drop_r && !ifu_icu_cancel) begin
                        data_nxt_s = biu_icu_data;
                        ex_nxt_s   = biu_icu_err;
                        dv_nxt_s   = 1'b1;
                    end else begin
                        drop_nxt_s = 1'b0;
                    end
                end else if (ifu_icu_cancel) begin
                    drop_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_BWAIT;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                drop_nxt_s    = 1'b0;
                biu_req_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM state and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            drop_r     <= 1'b0;
            tag_r      <= {ICU_TAG_W{1'b0}};
            biu_req_r  <= 1'b0;
            data_r     <= {BUS_DW{1'b0}};
            ex_r       <= 1'b0;
            dv_r       <= 1'b0;
            hit_pend_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            drop_r     <= drop_nxt_s;
            tag_r      <= tag_nxt_s;
            biu_req_r  <= biu_req_nxt_s;
            data_r     <= data_nxt_s;
            ex_r       <= ex_nxt_s;
            dv_r       <= dv_nxt_s;
            hit_pend_r <= hit_pend_nxt_s;
        end
    end

    assign icu_ifu_ack_ic1        = ack_s;
    assign icu_biu_req            = biu_req_r;
    assign icu_biu_addr           = {tag_r, {ICU_OFS_W{1'b0}}};
    assign icu_ifu_data_ic2       = data_r;
    assign icu_ifu_ex_ic2         = ex_r;
    // A buffer answer can still be withdrawn by a cancel in its own slot
    assign icu_ifu_data_valid_ic2 = dv_r & ~(hit_pend_r & ifu_icu_cancel);

endmodule

// File: tb/tb_cpu7_icu.sv
// Self-checking bench for cpu7_icu: per-cycle directed vector table plus an
// asynchronous-reset sequence. Line-buffer vectors are added under ICU_LINEBUF_EN.
module tb_cpu7_icu;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req, cancel, back, bdv, berr, ibar;
    logic [31:0] addr;
    logic [63:0] bdata;
    logic        ack, dv, ex, breq;
    logic [63:0] data;
    logic [31:0] baddr;

    always #5 clk = ~clk;

    cpu7_icu dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .ifu_icu_req_ic1        (req),
        .ifu_icu_addr_ic1       (addr),
        .icu_ifu_ack_ic1        (ack),
        .ifu_icu_cancel         (cancel),
        .icu_ifu_data_ic2       (data),
        .icu_ifu_data_valid_ic2 (dv),
        .icu_ifu_ex_ic2         (ex),
        .icu_biu_req            (breq),
        .icu_biu_addr           (baddr),
        .biu_icu_ack            (back),
        .biu_icu_data           (bdata),
        .biu_icu_data_valid     (bdv),
        .biu_icu_err            (berr),
        .exu_icu_ibar           (ibar)
    );

    // in_f = {req, cancel, biu_ack, biu_data_valid}; in_e = {biu_err, ibar}
    // exp_f = {ack, biu_req, data_valid, ex}; e_baddr checked when biu_req expected
    typedef struct {
        logic [3:0]  in_f;
        logic [1:0]  in_e;
        logic [31:0] addr;
        logic [63:0] bdat;
        logic [3:0]  exp_f;
        logic [31:0] e_baddr;
        logic [63:0] e_dat;
    } vec_t;

    vec_t        vq[$];
    int          checks = 0;
    int          failures = 0;
    logic [63:0] exp_data = 64'h0;

    task automatic add(input logic [3:0] in_f, input logic [1:0] in_e, input logic [31:0] a,
                       input logic [63:0] bd, input logic [3:0] exp_f,
                       input logic [31:0] eba, input logic [63:0] ed);
        vec_t v;
        v.in_f = in_f; v.in_e = in_e; v.addr = a; v.bdat = bd;
        v.exp_f = exp_f; v.e_baddr = eba; v.e_dat = ed;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%h expected=%h", name, idx, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag, input int idx);
        chk({tag, "_ack"}, idx, 64'(ack), 64'h0);
        chk({tag, "_biu_req"}, idx, 64'(breq), 64'h0);
        chk({tag, "_biu_addr"}, idx, 64'(baddr), 64'h0);
        chk({tag, "_data_valid"}, idx, 64'(dv), 64'h0);
        chk({tag, "_ex"}, idx, 64'(ex), 64'h0);
        chk({tag, "_data"}, idx, data, 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        {req, cancel, back, bdv} = 4'b0000;
        {berr, ibar} = 2'b00;
        addr = 32'h0;
        bdata = 64'h0;

        // zero-wait bus
        add(4'b1000, 2'b00, 32'h1c000004, 64'h0, 4'b1000, 32'h0, 64'h0);
        add(4'b0010, 2'b00, 32'h0, 64'h0, 4'b0100, 32'h1c000000, 64'h0);
        add(4'b0001, 2'b00, 32'h0, 64'h00000013_02800004, 4'b0000, 32'h0, 64'h0);
        add(4'b0000, 2'b00, 32'h0, 64'h0, 4'b0010, 32'h0, 64'h00000013_02800004);
        // bus ack delayed 3 cycles, request during BWAIT held off
        add(4'b1000, 2'b00, 32'h1c000040, 64'h0, 4'b1000, 32'h0, 64'h0);
        add(4'b0000, 2'b00, 32'h0, 64'h0, 4'b0100, 32'h1c000040, 64'h0);
        add(4'b0000, 2'b00, 32'h0, 64'h0, 4'b0100, 32'h1c000040, 64'h0);
        add(4'b0000, 2'b00, 32'h0, 64'h0, 4'b0100, 32'h1c000040, 64'h0);
        add(4'b0010, 2'b00, 32'h0, 64'h0, 4'b0100, 32'h1c000040, 64'h0);
        add(4'b1000, 2'b00, 32'h1c000008, 64'h0, 4'b0000, 32'h0, 64'h0);
        add(4'b1001, 2'b00, 32'h1c000008, 64'ha1a1a1a1_a1a1a1a1, 4'b0000, 32'h0, 64'h0);
        add(4'b1000, 2'b00, 32'h1c000008, 64'h0, 4'b1010, 32'h0, 64'ha1a1a1a1_a1a1a1a1);
        add(4'b0010, 2'b00, 32'h0, 64'h0, 4'b0100, 32'h1c000008, 64'h0);
        add(4'b0001, 2'b00, 32'h0, 64'ha2a2a2a2_a2a2a2a2, 4'b0000, 32'h0, 64'h0);
        add(4'b0000, 2'b00, 32'h0, 64'h0, 4'b0010, 32'h0, 64'ha2a2a2a2_a2a2a2a2);
        // cancel in BWAIT, new request waits for the drain
        add(4'b1000, 2'b00, 32'h1c000200, 64'h0, 4'b1000, 32'h0, 64'h0);
        add(4'b0010, 2'b00, 32'h0, 64'h0, 4'b0100, 32'h1c000200, 64'h0);
        add(4'b0100, 2'b00, 32'h0, 64'h0, 4'b0000, 32'h0, 64'h0);
        add(4'b1000, 2'b00, 32'h1c000100, 64'h0, 4'b0000, 32'h0, 64'h0);
        add(4'b1001, 2'b00, 32'h1c000100, 64'hb1b1b1b1_b1b1b1b1, 4'b0000, 32'h0, 64'h0);
        add(4'b1000, 2'b00, 32'h1c000100, 64'h0, 4'b1000, 32'h0, 64'h0);
        add(4'b0010, 2'b00, 32'h0, 64'h0, 4'b0100, 32'h1c000100, 64'h0);
        add(4'b0001, 2'b00, 32'h0, 64'hb2b2b2b2_b2b2b2b2, 4'b0000, 32'h0, 64'h0);
        add(4'b0000, 2'b00, 32'h0, 64'h0, 4'b0010, 32'h0, 64'hb2b2b2b2_b2b2b2b2);
        // cancel coinciding with bus data
        add(4'b1000, 2'b00, 32'h1c000300, 64'h0, 4'b1000, 32'h0, 64'h0);
        add(4'b0010, 2'b00, 32'h0, 64'h0, 4'b0100, 32'h1c000300, 64'h0);
        add(4'b0101, 2'b00, 32'h0, 64'hc1c1c1c1_c1c1c1c1, 4'b0000, 32'h0, 64'h0);
        add(4'b1000, 2'b00, 32'h1c000400, 64'h0, 4'b1000, 32'h0, 64'h0);
        add(4'b0010, 2'b00, 32'h0, 64'h0, 4'b0100, 32'h1c000400, 64'h0);
        add(4'b0001, 2'b00, 32'h0, 64'hc2c2c2c2_c2c2c2c2, 4'b0000, 32'h0, 64'h0);
        add(4'b0000, 2'b00, 32'h0, 64'h0, 4'b0010, 32'h0, 64'hc2c2c2c2_c2c2c2c2);
        // bus error, repeat request goes to the bus
        add(4'b1000, 2'b00, 32'h1c000500, 64'h0, 4'b1000, 32'h0, 64'h0);
        add(4'b0010, 2'b00, 32'h0, 64'h0, 4'b0100, 32'h1c000500, 64'h0);
        add(4'b0001, 2'b10, 32'h0, 64'he1e1e1e1_e1e1e1e1, 4'b0000, 32'h0, 64'h0);
        add(4'b1000, 2'b00, 32'h1c000500, 64'h0, 4'b1011, 32'h0, 64'he1e1e1e1_e1e1e1e1);
        add(4'b0010, 2'b00, 32'h0, 64'h0, 4'b0100, 32'h1c000500, 64'h0);
        add(4'b0001, 2'b00, 32'h0, 64'he2e2e2e2_e2e2e2e2, 4'b0000, 32'h0, 64'h0);
        add(4'b0000, 2'b00, 32'h0, 64'h0, 4'b0010, 32'h0, 64'he2e2e2e2_e2e2e2e2);
        // cancel in the ack cycle, then cancel while idle is ignored
        add(4'b1100, 2'b00, 32'h1c000600, 64'h0, 4'b1000, 32'h0, 64'h0);
        add(4'b0010, 2'b00, 32'h0, 64'h0, 4'b0100, 32'h1c000600, 64'h0);
        add(4'b0001, 2'b00, 32'h0, 64'hf1f1f1f1_f1f1f1f1, 4'b0000, 32'h0, 64'h0);
        add(4'b1000, 2'b00, 32'h1c000700, 64'h0, 4'b1000, 32'h0, 64'h0);
        add(4'b0010, 2'b00, 32'h0, 64'h0, 4'b0100, 32'h1c000700, 64'h0);
        add(4'b0001, 2'b00, 32'h0, 64'hf2f2f2f2_f2f2f2f2, 4'b0000, 32'h0, 64'h0);
        add(4'b0000, 2'b00, 32'h0, 64'h0, 4'b0010, 32'h0, 64'hf2f2f2f2_f2f2f2f2);
        add(4'b0100, 2'b00, 32'h0, 64'h0, 4'b0000, 32'h0, 64'h0);
        add(4'b1000, 2'b00, 32'h1c000800, 64'h0, 4'b1000, 32'h0, 64'h0);
        add(4'b0010, 2'b00, 32'h0, 64'h0, 4'b0100, 32'h1c000800, 64'h0);
        add(4'b0001, 2'b00, 32'h0, 64'hf3f3f3f3_f3f3f3f3, 4'b0000, 32'h0, 64'h0);
        add(4'b0000, 2'b00, 32'h0, 64'h0, 4'b0010, 32'h0, 64'hf3f3f3f3_f3f3f3f3);
`ifdef ICU_LINEBUF_EN
        // fill, hits at T+1, cancel in the hit slot, ibar, fill racing ibar
        add(4'b1000, 2'b00, 32'h1c000a00, 64'h0, 4'b1000, 32'h0, 64'h0);
        add(4'b0010, 2'b00, 32'h0, 64'h0, 4'b0100, 32'h1c000a00, 64'h0);
        add(4'b0001, 2'b00, 32'h0, 64'hd1d1d1d1_d1d1d1d1, 4'b0000, 32'h0, 64'h0);
        add(4'b1000, 2'b00, 32'h1c000a04, 64'h0, 4'b1010, 32'h0, 64'hd1d1d1d1_d1d1d1d1);
        add(4'b1000, 2'b00, 32'h1c000a00, 64'h0, 4'b1010, 32'h0, 64'hd1d1d1d1_d1d1d1d1);
        add(4'b1000, 2'b00, 32'h1c000a04, 64'h0, 4'b1010, 32'h0, 64'hd1d1d1d1_d1d1d1d1);
        add(4'b0100, 2'b00, 32'h0, 64'h0, 4'b0000, 32'h0, 64'h0);
        add(4'b0000, 2'b01, 32'h0, 64'h0, 4'b0000, 32'h0, 64'h0);
        add(4'b1000, 2'b00, 32'h1c000a00, 64'h0, 4'b1000, 32'h0, 64'h0);
        add(4'b0010, 2'b00, 32'h0, 64'h0, 4'b0100, 32'h1c000a00, 64'h0);
        add(4'b0001, 2'b01, 32'h0, 64'hd2d2d2d2_d2d2d2d2, 4'b0000, 32'h0, 64'h0);
        add(4'b1000, 2'b00, 32'h1c000a00, 64'h0, 4'b1010, 32'h0, 64'hd2d2d2d2_d2d2d2d2);
        add(4'b0010, 2'b00, 32'h0, 64'h0, 4'b0100, 32'h1c000a00, 64'h0);
        add(4'b0001, 2'b00, 32'h0, 64'hd3d3d3d3_d3d3d3d3, 4'b0000, 32'h0, 64'h0);
        add(4'b0000, 2'b00, 32'h0, 64'h0, 4'b0010, 32'h0, 64'hd3d3d3d3_d3d3d3d3);
`endif

        #12;
        chk_quiet("reset", -1);
        @(posedge clk); #1;
        resetn = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk); #1;
            {req, cancel, back, bdv} = vq[i].in_f;
            {berr, ibar} = vq[i].in_e;
            addr = vq[i].addr;
            bdata = vq[i].bdat;
            @(negedge clk);
            chk("ack", i, 64'(ack), 64'(vq[i].exp_f[3]));
            chk("biu_req", i, 64'(breq), 64'(vq[i].exp_f[2]));
            if (vq[i].exp_f[2]) chk("biu_addr", i, 64'(baddr), 64'(vq[i].e_baddr));
            chk("data_valid", i, 64'(dv), 64'(vq[i].exp_f[1]));
            if (vq[i].exp_f[1]) begin
                chk("ex", i, 64'(ex), 64'(vq[i].exp_f[0]));
                exp_data = vq[i].e_dat;
            end
            chk("data", i, data, exp_data);
        end

        // asynchronous reset while in BREQ, then a fresh fetch
        @(posedge clk); #1;
        {req, cancel, back, bdv} = 4'b1000;
        {berr, ibar} = 2'b00;
        addr = 32'h1c000900;
        @(negedge clk);
        chk("rst_seq_ack", 1000, 64'(ack), 64'h1);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("rst_seq_breq", 1001, 64'(breq), 64'h1);
        #2;
        resetn = 1'b0;
        #1;
        chk_quiet("midreset", 1002);
        @(posedge clk); #1;
        resetn = 1'b1;
        req = 1'b1;
        addr = 32'h1c000a40;
        @(negedge clk);
        chk("post_rst_ack", 1003, 64'(ack), 64'h1);
        @(posedge clk); #1;
        req = 1'b0;
        back = 1'b1;
        @(negedge clk);
        chk("post_rst_breq", 1004, 64'(breq), 64'h1);
        chk("post_rst_baddr", 1004, 64'(baddr), 64'h1c000a40);
        @(posedge clk); #1;
        back = 1'b0;
        bdv = 1'b1;
        bdata = 64'h5a5a5a5a_0123abcd;
        @(posedge clk); #1;
        bdv = 1'b0;
        @(negedge clk);
        chk("post_rst_dv", 1005, 64'(dv), 64'h1);
        chk("post_rst_data", 1005, data, 64'h5a5a5a5a_0123abcd);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
